// File: rtl/picorv32_dma_if.sv
// PicoRV32 native memory interface bundle between the DMA initiator and a responder.
interface picorv32_dma_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/picorv32_dma.sv
// Word-copy DMA engine on the PicoRV32 native memory interface. Each word is one read
// followed by one write, with a single idle cycle after every transaction. All outputs
// are registered; a bus timeout or misaligned start sets a sticky error.
module picorv32_dma #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [31:0]    src_addr,
    input  logic [31:0]    dst_addr,
    input  logic [15:0]    word_count,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [15:0]    words_done,
    picorv32_dma_if.master mem
);

    // Abort fires on the edge where the wait counter has already seen TIMEOUT-1 stalls.
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdGap,
        StWrReq,
        StWrGap
    } state_e;

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] words_q, words_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] words_inc;
    logic [31:0] word_offset;

    assign words_inc   = words_q + 16'd1;
    assign word_offset = 32'({words_q, 2'b00});

    // State and output registers; reset drops mem_valid asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            words_q <= 16'd0;
            valid_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'b0000;
            src_q   <= 32'd0;
            dst_q   <= 32'd0;
            cnt_q   <= 16'd0;
            data_q  <= 32'd0;
            tmo_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            words_q <= words_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        words_d = words_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (word_count == 16'd0) begin
                        done_d  = 1'b1;
                        error_d = 1'b0;
                    end else if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = word_count;
                        words_d = 16'd0;
                        error_d = 1'b0;
                        busy_d  = 1'b1;
                        valid_d = 1'b1;
                        addr_d  = src_addr;
                        wstrb_d = 4'b0000;
                        tmo_d   = 16'd0;
                        state_d = StRdReq;
                    end
                end
            end

            StRdReq: begin
                if (mem.mem_ready) begin
                    data_d  = mem.mem_rdata;
                    valid_d = 1'b0;
                    state_d = StRdGap;
                end else if (tmo_q == TmoLast) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            StRdGap: begin
                valid_d = 1'b1;
                addr_d  = dst_q + word_offset;
                wdata_d = data_q;
                wstrb_d = 4'b1111;
                tmo_d   = 16'd0;
                state_d = StWrReq;
            end

            StWrReq: begin
                if (mem.mem_ready) begin
                    words_d = words_inc;
                    valid_d = 1'b0;
                    // Finishing straight into idle lets done appear in the gap cycle, so a
                    // back-to-back start keeps the one-cycle bus gap.
                    if (words_inc == cnt_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StWrGap;
                    end
                end else if (tmo_q == TmoLast) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            StWrGap: begin
                valid_d = 1'b1;
                addr_d  = src_q + word_offset;
                wstrb_d = 4'b0000;
                tmo_d   = 16'd0;
                state_d = StRdReq;
            end

            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_done    = words_q;
    assign mem.mem_valid = valid_q;
    assign mem.mem_instr = 1'b0;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;

endmodule

// File: doc/picorv32_dma.md
# picorv32_dma

Memory-to-memory word-copy engine acting as an initiator on the PicoRV32 native memory interface (`mem_valid`/`mem_ready` handshake). A start request with source, destination and word count makes it issue alternating read and write transactions to any native-interface responder, such as the bench memory model or an on-chip SRAM wrapper. Status is reported as busy, a done pulse and a sticky error flag covering misalignment and bus timeout.

## Interface
- `TIMEOUT`, default 255: cycles `mem_valid` may stay high without `mem_ready` before the transfer aborts. Legal range 1..65535.
- `clk` in 1: clock, all logic on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request a transfer. Sampled only in IDLE.
- `src_addr` in 32: source byte address. Must be word-aligned.
- `dst_addr` in 32: destination byte address. Must be word-aligned.
- `word_count` in 16: number of 32-bit words to copy.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at the end of every accepted start, including error or zero-length cases.
- `error` out 1: sticky. Set on misalignment or timeout. Cleared when the next start is accepted.
- `words_done` out 16: words fully written in the current or last transfer.
- `mem_valid` out 1: transaction request.
- `mem_instr` out 1: constant 0.
- `mem_ready` in 1: responder completes the transaction in the cycle it is sampled high.
- `mem_addr` out 32: transaction byte address.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: 4'b0000 for a read, 4'b1111 for a write.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.

## Operation
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP.
- IDLE, on start with `word_count`==0:
  - `done` pulses next cycle.
  - No bus activity; `error` cleared.
- IDLE, on start with `src_addr[1:0]`!=0 or `dst_addr[1:0]`!=0:
  - `error` set, `done` pulses.
  - No bus activity.
- IDLE, on any other start:
  - Latch src, dst and count.
  - Clear `words_done` and `error`.
  - Go to RD_REQ.
- RD_REQ: `mem_valid`=1, `mem_addr`=src+4·`words_done`, `mem_wstrb`=0.
  - On sampled `mem_ready`, capture `mem_rdata` into a data register and go to RD_GAP.
- RD_GAP: `mem_valid`=0 for exactly one cycle, then WR_REQ.
- WR_REQ: `mem_valid`=1, `mem_addr`=dst+4·`words_done`, `mem_wdata`=captured word, `mem_wstrb`=4'b1111.
  - On sampled `mem_ready`, increment `words_done` and go to WR_GAP.
- WR_GAP: `mem_valid`=0 for one cycle.
  - If `words_done`==count: go to IDLE and pulse `done`.
  - Otherwise go to RD_REQ.
- Address arithmetic is 32-bit modulo: 0xFFFFFFFC+4 wraps to 0x00000000 with no error.
- Handshake rules while `mem_valid`=1:
  - `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable until `mem_ready` is sampled high.
  - `mem_valid` never drops before `mem_ready`, except on timeout.
- Timeout:
  - A counter increments each cycle in RD_REQ/WR_REQ without `mem_ready`, and resets on each new request.
  - When it reaches TIMEOUT: drop `mem_valid`, set `error`, pulse `done`, go to IDLE.
  - `words_done` keeps the count completed so far.
- `start` while `busy` is ignored, with no effect on latched operands.
- `mem_ready` sampled while `mem_valid`=0 is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `words_done`=0, `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `mem_instr`=0, state IDLE.
- Reset mid-transfer: `mem_valid` drops asynchronously; no further bus activity; no `done` pulse.
- All outputs are registered. `busy` and `mem_valid` rise on the edge that samples `start`, say edge E.
- For a responder that raises `mem_ready` for one cycle, one cycle after it sees `mem_valid` (registered, like the bench memory):
  - Each transaction takes 3 cycles: 2 with valid high, 1 gap.
  - Each word takes 6 cycles.
  - The write of word k completes at edge E+6k+5.
  - `done` is high, and `busy` low, in the cycle after edge E+6N-1.
- Zero-length and misaligned starts: `done` is high in the cycle after edge E; `busy` never rises.
- Timeout: `done` and `error` are asserted TIMEOUT cycles after `mem_valid` rose without a ready.
- The next `start` is accepted in the same cycle `done` is high.

## Test plan
- Copy 3 words, src=0x100, dst=0x200, memory[0x40..0x42]=0x11111111/0x22222222/0x33333333, with the registered one-cycle-latency responder:
  - memory[0x80..0x82] match the source words.
  - Bus sequence is R,W,R,W,R,W at 3-cycle spacing.
  - `done` is high in the cycle after edge E+17.
  - `words_done`=3, `error`=0.
- `word_count`=0 → `done` one cycle later, `mem_valid` never high, `error`=0.
- src=0x102 → `error`=1, `done` pulse, no bus activity. A following valid start clears `error`.
- Responder never asserts ready, TIMEOUT=16 → `mem_valid` high 16 cycles then low, `error`=1, `done` pulse, `words_done`=0.
- src=0xFFFFFFFC, count=2 → second read address is 0x00000000.
- `resetn` low during the second word's WR_REQ → `mem_valid` and `busy` drop immediately, no `done`.
- `start` pulsed while busy, with different operands → ignored; the original transfer completes unchanged.
